// File: rtl/core_lsu.sv
// ============================================================================
// core_lsu: multi-cycle load/store unit between execute and the data bus.
// It handles lane alignment, byte strobes, load extension and bus-word split.
// The optional two-beat crossing support is enabled by LSU_MISALIGN_SPLIT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_lsu #(
    parameter int XLEN      = 32,
    parameter int BUS_BYTES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_dir,
    input  logic [2:0]             req_size,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    output logic                   rsp_valid,
    output logic [XLEN-1:0]        rsp_rdata,
    output logic                   rsp_fault,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [BUS_BYTES-1:0]   mem_wstrb,
    output logic [8*BUS_BYTES-1:0] mem_wdata,
    input  logic                   mem_rvalid,
    input  logic [8*BUS_BYTES-1:0] mem_rdata,
    input  logic                   mem_err
);

    localparam int OW = $clog2(BUS_BYTES);
    localparam int BW = 8 * BUS_BYTES;
    localparam int CW = OW + 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
`endif
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]          r_state;
    logic                r_dir;
    logic [2:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [BW-1:0]       r_rdata0;
    logic                r_err;

    logic                w_illegal;
    logic                w_cross;
    logic                w_fault_now;
    logic [OW-1:0]       w_off;
    logic [3:0]          w_nbytes;
    logic [ADDR_W-1:0]   w_base;
    logic [2*BUS_BYTES-1:0] w_nmask;
    logic [2*BUS_BYTES-1:0] w_strb_wide;
    logic [2*BW-1:0]     w_wdata_wide;
    logic [BW-1:0]       w_rd_hi;
    logic [XLEN-1:0]     w_rd_aligned;
    logic [6:0]          w_shamt;
    logic [XLEN-1:0]     w_shl;
    logic [XLEN-1:0]     w_srl;
    logic signed [XLEN-1:0] w_sra;

    // Crossing is judged on the incoming request so the decision is made at accept.
    logic [CW-1:0]       w_end;
    assign w_end     = CW'(req_addr[OW-1:0]) + CW'(4'd1 << req_size[1:0]);
    assign w_cross   = (w_end > CW'(BUS_BYTES));
    assign w_illegal = (req_size == 3'b111) ||
                       ((XLEN == 32) && ((req_size == 3'b011) || (req_size == 3'b110)));
`ifdef LSU_MISALIGN_SPLIT_EN
    logic                r_split;
    logic [BW-1:0]       r_rdata1;
    assign w_fault_now = w_illegal;
    assign w_rd_hi     = r_rdata1;
`else
    assign w_fault_now = w_illegal | w_cross;
    assign w_rd_hi     = '0;
`endif

    assign w_off    = r_addr[OW-1:0];
    assign w_nbytes = 4'd1 << r_size[1:0];
    assign w_base   = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};

    always_comb begin
        w_nmask = '0;
        case (r_size[1:0])
            2'd0:    w_nmask = (2*BUS_BYTES)'(1);
            2'd1:    w_nmask = (2*BUS_BYTES)'(3);
            2'd2:    w_nmask = (2*BUS_BYTES)'(15);
            default: w_nmask = (2*BUS_BYTES)'(255);
        endcase
    end

    // Both beats come from one double-width shift: low half is beat 0, high half beat 1.
    assign w_strb_wide  = w_nmask << w_off;
    assign w_wdata_wide = (2*BW)'(r_wdata) << {w_off, 3'b000};

    assign w_rd_aligned = XLEN'({w_rd_hi, r_rdata0} >> {w_off, 3'b000});
    assign w_shamt      = 7'(XLEN) - {w_nbytes, 3'b000};
    assign w_shl        = w_rd_aligned << w_shamt;
    assign w_srl        = w_shl >> w_shamt;
    assign w_sra        = $signed(w_shl) >>> w_shamt;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_fault = (r_state == S_RESP) && r_err;
    assign rsp_rdata = ((r_state == S_RESP) && !r_err && !r_dir)
                       ? (r_size[2] ? w_srl : XLEN'(w_sra)) : '0;

    always_comb begin
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (r_state == S_REQ0) begin
            mem_valid = 1'b1;
            mem_write = r_dir;
            mem_addr  = w_base;
            mem_wstrb = BUS_BYTES'(w_strb_wide);
            mem_wdata = BW'(w_wdata_wide);
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (r_state == S_REQ1) begin
            mem_valid = 1'b1;
            mem_write = r_dir;
            mem_addr  = w_base + ADDR_W'(BUS_BYTES);
            mem_wstrb = BUS_BYTES'(w_strb_wide >> BUS_BYTES);
            mem_wdata = BW'(w_wdata_wide >> BW);
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_dir    <= 1'b0;
            r_size   <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_err    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split  <= 1'b0;
            r_rdata1 <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_dir    <= req_dir;
                        r_size   <= req_size;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata0 <= '0;
                        r_err    <= w_fault_now;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_split  <= w_cross;
                        r_rdata1 <= '0;
`endif
                        r_state  <= w_fault_now ? S_RESP : S_REQ0;
                    end
                end
                S_REQ0: begin
                    if (mem_ready) r_state <= S_WAIT0;
                end
                S_WAIT0: begin
                    if (mem_rvalid) begin
                        r_rdata0 <= mem_rdata;
                        if (mem_err) r_err <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_state  <= (r_split && !mem_err) ? S_REQ1 : S_RESP;
`else
                        r_state  <= S_RESP;
`endif
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_REQ1: begin
                    if (mem_ready) r_state <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        r_rdata1 <= mem_rdata;
                        if (mem_err) r_err <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_lsu.sv
// ============================================================================
// tb_core_lsu: directed self-checking bench for core_lsu (XLEN=32, 4-byte bus).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_dir;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid, mem_err;

    always #5 clk = ~clk;

    core_lsu #(.XLEN(32), .BUS_BYTES(4), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        o_rsp, o_fault, o_after_valid, o_after_ready, o_stable, o_mv_seen;
    logic [31:0] o_rdata;
    int          o_lat, o_beats;
    logic [31:0] b_addr  [2];
    logic [3:0]  b_strb  [2];
    logic [31:0] b_wdata [2];
    logic        b_write [2];

    // Issues one request at the current negedge and plays a bus that answers
    // one cycle after each accept; stall delays mem_ready on the first beat.
    task automatic run_txn(input logic dir, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
                           input logic err0, input int stall);
        int   beat;
        int   stall_left;
        logic pending;
        logic seen [2];
        beat = 0; pending = 1'b0; stall_left = stall;
        seen[0] = 1'b0; seen[1] = 1'b0;
        o_rsp = 1'b0; o_fault = 1'b0; o_rdata = 32'hx; o_lat = 0; o_mv_seen = 1'b0; o_stable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = 32'hx; b_strb[i] = 4'hx; b_wdata[i] = 32'hx; b_write[i] = 1'bx;
        end
        req_valid = 1'b1; req_dir = dir; req_size = size; req_addr = addr; req_wdata = wdata;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
            if (pending) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (beat == 0) ? rd0 : rd1;
                mem_err    = (beat == 0) ? err0 : 1'b0;
                pending    = 1'b0;
                beat++;
            end
            if (rsp_valid) begin
                o_rsp = 1'b1; o_lat = k; o_rdata = rsp_rdata; o_fault = rsp_fault;
                break;
            end
            if (mem_valid) begin
                o_mv_seen = 1'b1;
                if (beat < 2) begin
                    if (seen[beat]) begin
                        if (b_addr[beat] !== mem_addr || b_strb[beat] !== mem_wstrb ||
                            b_wdata[beat] !== mem_wdata || b_write[beat] !== mem_write)
                            o_stable = 1'b0;
                    end else begin
                        seen[beat]    = 1'b1;
                        b_addr[beat]  = mem_addr;  b_strb[beat]  = mem_wstrb;
                        b_wdata[beat] = mem_wdata; b_write[beat] = mem_write;
                    end
                end
                if (stall_left > 0) stall_left--;
                else begin
                    mem_ready = 1'b1;
                    pending   = 1'b1;
                end
            end
        end
        o_beats = beat;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        @(negedge clk);
        o_after_valid = rsp_valid;
        o_after_ready = req_ready;
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0) begin
            n_errors++; $display("FAIL reset_rsp: got ready=%b valid=%b fault=%b expected 1 0 0", req_ready, rsp_valid, rsp_fault); end
        n_checks++; if (mem_valid !== 1'b0 || mem_write !== 1'b0) begin
            n_errors++; $display("FAIL reset_mem_ctl: got valid=%b write=%b expected 0 0", mem_valid, mem_write); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_data: got addr=%h strb=%h wdata=%h rdata=%h expected all 0", mem_addr, mem_wstrb, mem_wdata, rsp_rdata); end
    endtask

    task automatic test_load_word();
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        n_checks++; if (b_addr[0] !== 32'h100 || b_strb[0] !== 4'hF || b_write[0] !== 1'b0) begin
            n_errors++; $display("FAIL lw_bus: got addr=%h strb=%h write=%b expected 100 f 0", b_addr[0], b_strb[0], b_write[0]); end
        n_checks++; if (o_rdata !== 32'hDEADBEEF || o_fault !== 1'b0) begin
            n_errors++; $display("FAIL lw_rdata: got %h fault=%b expected deadbeef 0", o_rdata, o_fault); end
        n_checks++; if (o_lat !== 3) begin
            n_errors++; $display("FAIL lw_latency: got %0d expected 3", o_lat); end
        n_checks++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin
            n_errors++; $display("FAIL lw_pulse: got valid=%b ready=%b expected 0 1", o_after_valid, o_after_ready); end
    endtask

    task automatic test_load_byte_half();
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b0, 0);
        n_checks++; if (o_rdata !== 32'hFFFFFF80 || b_strb[0] !== 4'b1000) begin
            n_errors++; $display("FAIL lb_sext: got %h strb=%b expected ffffff80 1000", o_rdata, b_strb[0]); end
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b0, 0);
        n_checks++; if (o_rdata !== 32'h00000080) begin
            n_errors++; $display("FAIL lbu_zext: got %h expected 00000080", o_rdata); end
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 32'h0, 1'b0, 0);
        n_checks++; if (o_rdata !== 32'hFFFF8001) begin
            n_errors++; $display("FAIL lh_sext: got %h expected ffff8001", o_rdata); end
    endtask

    task automatic test_store();
        run_txn(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 32'h0, 1'b0, 0);
        n_checks++; if (b_strb[0] !== 4'b1100 || b_wdata[0] !== 32'h12340000 || b_write[0] !== 1'b1) begin
            n_errors++; $display("FAIL sh_lanes: got strb=%b wdata=%h write=%b expected 1100 12340000 1", b_strb[0], b_wdata[0], b_write[0]); end
        n_checks++; if (o_rdata !== 32'h0 || o_fault !== 1'b0 || b_addr[0] !== 32'h100) begin
            n_errors++; $display("FAIL sh_rsp: got rdata=%h fault=%b addr=%h expected 0 0 100", o_rdata, o_fault, b_addr[0]); end
        // Misaligned but inside one bus word: single beat, no fault.
        run_txn(1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0, 32'h0, 1'b0, 0);
        n_checks++; if (b_strb[0] !== 4'b0110 || b_wdata[0] !== 32'h00BEEF00 || o_fault !== 1'b0 || o_beats !== 1) begin
            n_errors++; $display("FAIL sh_inword: got strb=%b wdata=%h fault=%b beats=%0d expected 0110 00beef00 0 1", b_strb[0], b_wdata[0], o_fault, o_beats); end
    endtask

    task automatic test_crossing();
`ifdef LSU_MISALIGN_SPLIT_EN
        run_txn(1'b1, 3'b010, 32'h0FE, 32'hAABBCCDD, 32'h0, 32'h0, 1'b0, 0);
        n_checks++; if (b_addr[0] !== 32'h0FC || b_strb[0] !== 4'b1100 || b_wdata[0] !== 32'hCCDD0000) begin
            n_errors++; $display("FAIL split_beat0: got addr=%h strb=%b wdata=%h expected 0fc 1100 ccdd0000", b_addr[0], b_strb[0], b_wdata[0]); end
        n_checks++; if (b_addr[1] !== 32'h100 || b_strb[1] !== 4'b0011 || b_wdata[1] !== 32'h0000AABB) begin
            n_errors++; $display("FAIL split_beat1: got addr=%h strb=%b wdata=%h expected 100 0011 0000aabb", b_addr[1], b_strb[1], b_wdata[1]); end
        n_checks++; if (o_lat !== 5 || o_fault !== 1'b0 || o_beats !== 2) begin
            n_errors++; $display("FAIL split_store_rsp: got lat=%0d fault=%b beats=%0d expected 5 0 2", o_lat, o_fault, o_beats); end
        run_txn(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h11223344, 32'h55667788, 1'b0, 0);
        n_checks++; if (o_rdata !== 32'h77881122) begin
            n_errors++; $display("FAIL split_load: got %h expected 77881122", o_rdata); end
        run_txn(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h11223344, 32'h55667788, 1'b1, 0);
        n_checks++; if (o_fault !== 1'b1 || o_rdata !== 32'h0 || o_beats !== 1 || o_lat !== 3) begin
            n_errors++; $display("FAIL split_err0: got fault=%b rdata=%h beats=%0d lat=%0d expected 1 0 1 3", o_fault, o_rdata, o_beats, o_lat); end
`else
        run_txn(1'b1, 3'b010, 32'h0FE, 32'hAABBCCDD, 32'h0, 32'h0, 1'b0, 0);
        n_checks++; if (o_fault !== 1'b1 || o_mv_seen !== 1'b0 || o_lat !== 1) begin
            n_errors++; $display("FAIL cross_store: got fault=%b mem_valid_seen=%b lat=%0d expected 1 0 1", o_fault, o_mv_seen, o_lat); end
        run_txn(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h11223344, 32'h55667788, 1'b0, 0);
        n_checks++; if (o_fault !== 1'b1 || o_mv_seen !== 1'b0 || o_rdata !== 32'h0) begin
            n_errors++; $display("FAIL cross_load: got fault=%b mem_valid_seen=%b rdata=%h expected 1 0 0", o_fault, o_mv_seen, o_rdata); end
`endif
    endtask

    task automatic test_errors();
        run_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        n_checks++; if (o_fault !== 1'b1 || o_rdata !== 32'h0 || b_addr[0] !== 32'h104) begin
            n_errors++; $display("FAIL bus_err: got fault=%b rdata=%h addr=%h expected 1 0 104", o_fault, o_rdata, b_addr[0]); end
        run_txn(1'b0, 3'b111, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        n_checks++; if (o_fault !== 1'b1 || o_mv_seen !== 1'b0 || o_lat !== 1) begin
            n_errors++; $display("FAIL illegal_111: got fault=%b mem_valid_seen=%b lat=%0d expected 1 0 1", o_fault, o_mv_seen, o_lat); end
        run_txn(1'b1, 3'b011, 32'h200, 32'h1, 32'h0, 32'h0, 1'b0, 0);
        n_checks++; if (o_fault !== 1'b1 || o_mv_seen !== 1'b0) begin
            n_errors++; $display("FAIL illegal_d: got fault=%b mem_valid_seen=%b expected 1 0", o_fault, o_mv_seen); end
        run_txn(1'b0, 3'b110, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        n_checks++; if (o_fault !== 1'b1 || o_mv_seen !== 1'b0) begin
            n_errors++; $display("FAIL illegal_wu: got fault=%b mem_valid_seen=%b expected 1 0", o_fault, o_mv_seen); end
    endtask

    task automatic test_stall();
        run_txn(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 32'h0, 1'b0, 5);
        n_checks++; if (o_stable !== 1'b1) begin
            n_errors++; $display("FAIL stall_stable: got stable=%b expected 1", o_stable); end
        n_checks++; if (b_addr[0] !== 32'h200 || b_strb[0] !== 4'b0010 || b_wdata[0] !== 32'h0000A500) begin
            n_errors++; $display("FAIL stall_bus: got addr=%h strb=%b wdata=%h expected 200 0010 0000a500", b_addr[0], b_strb[0], b_wdata[0]); end
        n_checks++; if (o_lat !== 8) begin
            n_errors++; $display("FAIL stall_latency: got %0d expected 8", o_lat); end
    endtask

    task automatic test_reset_mid();
        logic saw_rsp;
        req_valid = 1'b1; req_dir = 1'b0; req_size = 3'b010; req_addr = 32'h300; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_idle: got ready=%b mem_valid=%b expected 1 0", req_ready, mem_valid); end
        rstn = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        saw_rsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        n_checks++; if (saw_rsp !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++; $display("FAIL midrst_late_rvalid: got rsp_seen=%b ready=%b expected 0 1", saw_rsp, req_ready); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 32'h0, 1'b0, 0);
        n_checks++; if (o_rdata !== 32'h00008001 || o_lat !== 3) begin
            n_errors++; $display("FAIL b2b_lhu: got %h lat=%0d expected 00008001 3", o_rdata, o_lat); end
        run_txn(1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 32'h0, 1'b0, 0);
        n_checks++; if (o_rdata !== 32'h0000007F || o_lat !== 3) begin
            n_errors++; $display("FAIL b2b_lb_pos: got %h lat=%0d expected 0000007f 3", o_rdata, o_lat); end
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0; req_dir = 1'b0; req_size = 3'b0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_load_word();
        test_load_byte_half();
        test_store();
        test_crossing();
        test_errors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
